// File: rtl/vmw_reg_wr_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter: state encoding and
// default bank geometry.
package vmw_reg_wr_arbiter_pkg;

    localparam int DEF_NREQ  = 4;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_CLEAR = 3'd2,
        ST_ACK   = 3'd3,
        ST_COOL  = 3'd4
    } arb_state_e;

endpackage

// File: rtl/vmw_reg_wr_arbiter_if.sv
// Requester/bank-side bundle of the write arbiter. The slave modport is the
// arbiter; the master modport is the requester and bank side.
interface vmw_reg_wr_arbiter_if
    import vmw_reg_wr_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       gnt;
    logic                  sclr_req;
    logic                  sclr_ack;
    logic                  busy;
    logic [WIDTH-1:0]      reg_d;
    logic                  reg_ce;
    logic                  reg_sclr;

    modport master (
        output req, wdata, sclr_req,
        input  ack, gnt, sclr_ack, busy, reg_d, reg_ce, reg_sclr
    );

    modport slave (
        input  req, wdata, sclr_req,
        output ack, gnt, sclr_ack, busy, reg_d, reg_ce, reg_sclr
    );

endinterface

// File: rtl/vmw_rr_pick.sv
// Combinational round-robin picker: first set request at or above rr_ptr_i,
// wrapping modulo NREQ.
module vmw_rr_pick
#(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   rr_ptr_i,
    output logic [NREQ-1:0] onehot_o,
    output logic [PW-1:0]   idx_o,
    output logic            valid_o
);

    // Scan from the pointer upward; the first hit latches and masks the rest.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        valid_o  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int  sum_v;
            int  k_v;
            logic hit_v;
            sum_v       = int'(rr_ptr_i) + i;
            k_v         = (sum_v >= NREQ) ? (sum_v - NREQ) : sum_v;
            hit_v       = ~valid_o & req_i[k_v];
            onehot_o[k_v] = onehot_o[k_v] | hit_v;
            idx_o       = hit_v ? PW'(k_v) : idx_o;
            valid_o     = valid_o | hit_v;
        end
    end

endmodule

// File: rtl/vmw_reg_wr_arbiter.sv
// Round-robin write arbiter for a shared VMW_FDSCE register bank, with a
// priority synchronous-clear path. Every output comes straight from a flop.
module vmw_reg_wr_arbiter
    import vmw_reg_wr_arbiter_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                  CP,
    input  logic                  CLR,
    vmw_reg_wr_arbiter_if.slave   bus
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e       state_q;
    logic [PW-1:0]    rr_ptr_q;
    logic [NREQ-1:0]  ack_q;
    logic [NREQ-1:0]  gnt_q;
    logic             sclr_ack_q;
    logic             busy_q;
    logic [WIDTH-1:0] reg_d_q;
    logic             reg_ce_q;
    logic             reg_sclr_q;

    logic [NREQ-1:0]  pick_onehot_s;
    logic [PW-1:0]    pick_idx_s;
    logic             pick_valid_s;
    logic [WIDTH-1:0] sel_data_s;

    vmw_rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_pick (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .onehot_o (pick_onehot_s),
        .idx_o    (pick_idx_s),
        .valid_o  (pick_valid_s)
    );

    // Select the winner's write data slice.
    always_comb begin
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_data_s = (pick_idx_s == PW'(i)) ? bus.wdata[i*WIDTH +: WIDTH] : sel_data_s;
        end
    end

    // Arbitration FSM; COOL absorbs one cycle of requester deassert latency.
    always_ff @(posedge CP or posedge CLR) begin
        if (CLR) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            ack_q      <= '0;
            gnt_q      <= '0;
            sclr_ack_q <= 1'b0;
            busy_q     <= 1'b0;
            reg_d_q    <= '0;
            reg_ce_q   <= 1'b0;
            reg_sclr_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.sclr_req) begin
                        state_q    <= ST_CLEAR;
                        reg_sclr_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (pick_valid_s) begin
                        state_q  <= ST_WRITE;
                        reg_ce_q <= 1'b1;
                        reg_d_q  <= sel_data_s;
                        gnt_q    <= pick_onehot_s;
                        busy_q   <= 1'b1;
                        if (pick_idx_s == PW'(NREQ - 1)) begin
                            rr_ptr_q <= '0;
                        end else begin
                            rr_ptr_q <= pick_idx_s + PW'(1);
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    reg_ce_q <= 1'b0;
                    ack_q    <= gnt_q;
                    state_q  <= ST_ACK;
                end
                ST_CLEAR: begin
                    reg_sclr_q <= 1'b0;
                    sclr_ack_q <= 1'b1;
                    state_q    <= ST_ACK;
                end
                ST_ACK: begin
                    ack_q      <= '0;
                    sclr_ack_q <= 1'b0;
                    gnt_q      <= '0;
                    state_q    <= ST_COOL;
                end
                ST_COOL: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    ack_q      <= '0;
                    gnt_q      <= '0;
                    sclr_ack_q <= 1'b0;
                    busy_q     <= 1'b0;
                    reg_ce_q   <= 1'b0;
                    reg_sclr_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ack      = ack_q;
    assign bus.gnt      = gnt_q;
    assign bus.sclr_ack = sclr_ack_q;
    assign bus.busy     = busy_q;
    assign bus.reg_d    = reg_d_q;
    assign bus.reg_ce   = reg_ce_q;
    assign bus.reg_sclr = reg_sclr_q;

endmodule
